// File: rtl/xnor_match_pkg.sv
// Shared constants and helpers for the xnor_match_unit slice.
// Used by the RTL and by the testbench.
package xnor_match_pkg;

  localparam int DEFAULT_CNT_W = 16;

  // Bits needed to hold a population count of 0..width.
  function automatic int ones_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/xnor_match_unit_popcount.sv
// Combinational population count. The sum is built as a ripple chain of
// partial sums, which keeps the result exact for any WIDTH >= 1.
module xnor_popcount
  import xnor_match_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int ONES_W = ones_width(WIDTH)
) (
  input  logic [WIDTH-1:0]  x,
  output logic [ONES_W-1:0] cnt
);

  logic [ONES_W-1:0] partial [WIDTH+1];

  assign partial[0] = '0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum
    assign partial[gi+1] = partial[gi] + ONES_W'(x[gi]);
  end

  assign cnt = partial[WIDTH];

endmodule

// File: rtl/xnor_match_unit.sv
// Two-stage valid/ready pipeline: per-bit XNOR, match count, equality flag,
// plus a saturating count of equal transfers. Optional mask: XNOR_MATCH_MASK_EN.
module xnor_match_unit
  import xnor_match_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = DEFAULT_CNT_W,
  localparam int ONES_W = ones_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
`ifdef XNOR_MATCH_MASK_EN
  input  logic [WIDTH-1:0]  mask,
`endif
  input  logic              clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  f,
  output logic [ONES_W-1:0] ones,
  output logic              eq,
  output logic [CNT_W-1:0]  match_cnt
);

  logic              s1_valid_reg;
  logic [WIDTH-1:0]  s1_x_reg;
  logic              s2_valid_reg;
  logic [WIDTH-1:0]  f_reg;
  logic [ONES_W-1:0] ones_reg;
  logic              eq_reg;
  logic [CNT_W-1:0]  match_cnt_reg;

  logic              s1_adv;
  logic              s2_adv;
  logic [WIDTH-1:0]  x_next;
  logic [ONES_W-1:0] s1_ones;
  logic              out_fire;

  // A stage may load when it is empty or its contents move on this edge.
  assign s2_adv   = ~s2_valid_reg | out_ready;
  assign s1_adv   = ~s1_valid_reg | s2_adv;
  assign in_ready = s1_adv;
  assign out_fire = s2_valid_reg & out_ready;

`ifdef XNOR_MATCH_MASK_EN
  assign x_next = ~(a ^ b) | mask;
`else
  assign x_next = ~(a ^ b);
`endif

  xnor_popcount #(.WIDTH(WIDTH)) u_popcount (
    .x   (s1_x_reg),
    .cnt (s1_ones)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_x_reg     <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) s1_x_reg <= x_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      f_reg        <= '0;
      ones_reg     <= '0;
      eq_reg       <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        f_reg    <= s1_x_reg;
        ones_reg <= s1_ones;
        eq_reg   <= &s1_x_reg;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt_reg <= '0;
    end else if (clr) begin
      match_cnt_reg <= '0;
    end else if (out_fire && eq_reg && (match_cnt_reg != '1)) begin
      match_cnt_reg <= match_cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid_reg;
  assign f         = f_reg;
  assign ones      = ones_reg;
  assign eq        = eq_reg;
  assign match_cnt = match_cnt_reg;

endmodule
